// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter that turns two requesters' byte transactions into the
// RAM's 10-bit command words and routes read data (or a timeout) back.
module ram_cmd_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             req_valid,
    input  logic [1:0]             req_we,
    input  logic [2*ADDR_SIZE-1:0] req_addr,
    input  logic [2*ADDR_SIZE-1:0] req_wdata,
    output logic [1:0]             req_ready,
    output logic [1:0]             rsp_valid,
    output logic [ADDR_SIZE-1:0]   rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_SIZE+1:0]   ram_din,
    output logic                   ram_rx_valid,
    input  logic [ADDR_SIZE-1:0]   ram_dout,
    input  logic                   ram_tx_valid,
    output logic                   busy
);
    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE, CMD_ADDR, CMD_WDATA, CMD_RDATA, WAIT_RD, RESP
    } state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;
    logic                 id_q, id_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [ADDR_SIZE-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
    logic                 err_q, err_d;
    logic [ADDR_SIZE+1:0] din_q, din_d;
    logic                 rxv_q, rxv_d;
    logic [1:0]           rspv_q, rspv_d;
    logic [1:0]           grant;
    logic                 hs;
    logic                 gnt_id;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant = req_valid;
        if (req_valid == 2'b11) grant = last_q ? 2'b01 : 2'b10;
    end

    assign req_ready    = (state_q == IDLE) ? grant : 2'b00;
    assign hs           = |req_ready;
    assign gnt_id       = req_ready[1];
    assign busy         = (state_q != IDLE);
    assign ram_din      = din_q;
    assign ram_rx_valid = rxv_q;
    assign rsp_valid    = rspv_q;
    assign rsp_rdata    = rdata_q;
    assign rsp_err      = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            din_q   <= '0;
            rxv_q   <= 1'b0;
            rspv_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            din_q   <= din_d;
            rxv_q   <= rxv_d;
            rspv_q  <= rspv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = CMD_ADDR;
                    last_d  = gnt_id;
                    id_d    = gnt_id;
                    we_d    = req_we[gnt_id];
                    addr_d  = gnt_id ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
                    wdata_d = gnt_id ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata[ADDR_SIZE-1:0];
                end
            end
            CMD_ADDR:  state_d = we_q ? CMD_WDATA : CMD_RDATA;
            CMD_WDATA: state_d = IDLE;
            CMD_RDATA: begin
                state_d = WAIT_RD;
                cnt_d   = '0;
            end
            // A response arriving on the last allowed cycle still beats the timeout.
            WAIT_RD: begin
                if (ram_tx_valid) begin
                    rdata_d = ram_dout;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // RAM strobes and response strobes are registered from the next state.
    always_comb begin
        din_d  = '0;
        rxv_d  = 1'b0;
        rspv_d = 2'b00;
        case (state_d)
            CMD_ADDR: begin
                rxv_d = 1'b1;
                din_d = {(we_d ? 2'b00 : 2'b10), addr_d};
            end
            CMD_WDATA: begin
                rxv_d = 1'b1;
                din_d = {2'b01, wdata_d};
            end
            CMD_RDATA: begin
                rxv_d = 1'b1;
                din_d = {2'b11, {ADDR_SIZE{1'b0}}};
            end
            RESP:    rspv_d = id_d ? 2'b10 : 2'b01;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Randomized bench for ram_cmd_arbiter: a transaction-level timeline model
// predicts every output per cycle; directed scenarios pin literal values.
module tb_ram_cmd_arbiter;
    localparam int AW = 8;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_we = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [9:0]  ram_din;
    logic        ram_rx_valid;
    logic [7:0]  ram_dout = '0;
    logic        ram_tx_valid = 1'b0;
    logic        busy;

    ram_cmd_arbiter #(.ADDR_SIZE(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid), .ram_dout(ram_dout),
        .ram_tx_valid(ram_tx_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] din;
        logic       rxv;
        logic [1:0] rspv;
        logic       upd;
        logic [7:0] rdata;
        logic       err;
    } slot_t;

    slot_t       plan[$];
    logic [7:0]  mem[256];
    int          n_chk = 0;
    int          n_fail = 0;
    int          slot = 0;
    int          m_last = 1;
    logic [7:0]  m_rdata = '0;
    logic        m_err = 1'b0;
    int          tx_at = -1;
    logic [7:0]  tx_data = '0;
    int          rd_end = -1;

    logic [1:0]  s_valid = '0;
    logic [1:0]  s_we = '0;
    logic [15:0] s_addr = '0;
    logic [15:0] s_wdata = '0;
    logic        s_rst = 1'b1;
    logic        s_spur = 1'b0;
    int          s_dly = 0;

    logic [9:0]  rx_log[$];
    int          gnt_log[$];
    int          hs_log[$];
    int          rsp_slot_log[$];
    logic [1:0]  rspv_log[$];
    logic [7:0]  rdat_log[$];
    logic        err_log[$];

    function automatic slot_t mk(logic [9:0] din, logic rxv, logic [1:0] rspv,
                                 logic upd, logic [7:0] rdata, logic err);
        slot_t s;
        s.din = din; s.rxv = rxv; s.rspv = rspv; s.upd = upd; s.rdata = rdata; s.err = err;
        return s;
    endfunction

    function automatic logic [9:0] rx(int i);
        return (i < rx_log.size()) ? rx_log[i] : 10'h3FF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at slot %0d: got 0x%0h, expected 0x%0h", name, slot, got, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [1:0] we,
                           input logic [15:0] a, input logic [15:0] w);
        s_valid = v; s_we = we; s_addr = a; s_wdata = w;
    endtask

    task automatic cycle();
        slot_t      e;
        logic       idle;
        int         g;
        logic [1:0] exp_rdy;
        logic [7:0] a, w;
        @(negedge clk);
        slot++;
        idle = (plan.size() == 0);
        e = mk('0, 1'b0, 2'b00, 1'b0, '0, 1'b0);
        if (!idle) e = plan.pop_front();
        if (e.upd) begin
            m_rdata = e.rdata;
            m_err   = e.err;
        end
        chk("ram_din", 32'(ram_din), 32'(e.din));
        chk("ram_rx_valid", 32'(ram_rx_valid), 32'(e.rxv));
        chk("rsp_valid", 32'(rsp_valid), 32'(e.rspv));
        chk("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        chk("busy", 32'(busy), 32'(!idle));
        if (ram_rx_valid === 1'b1) rx_log.push_back(ram_din);
        if (rsp_valid !== 2'b00) begin
            rsp_slot_log.push_back(slot);
            rspv_log.push_back(rsp_valid);
            rdat_log.push_back(rsp_rdata);
            err_log.push_back(rsp_err);
        end

        rst_n = !s_rst;
        if (s_rst) begin
            plan.delete();
            m_last  = 1;
            m_rdata = '0;
            m_err   = 1'b0;
            tx_at   = -1;
        end
        ram_tx_valid = 1'b0;
        ram_dout     = 8'($urandom);
        if (!s_rst && tx_at == slot) begin
            ram_tx_valid = 1'b1;
            ram_dout     = tx_data;
            tx_at        = -1;
        end else if (s_spur && tx_at < 0 && slot > rd_end) begin
            ram_tx_valid = 1'b1;
        end
        req_valid = s_valid; req_we = s_we; req_addr = s_addr; req_wdata = s_wdata;
        #1;
        if (!s_rst) begin
            g = (s_valid == 2'b11) ? (1 - m_last) : (s_valid[1] ? 1 : 0);
            exp_rdy = (idle && s_valid != 2'b00) ? 2'(1 << g) : 2'b00;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            if (exp_rdy != 2'b00) begin
                m_last = g;
                gnt_log.push_back(g);
                hs_log.push_back(slot);
                a = s_addr[g*8 +: 8];
                w = s_wdata[g*8 +: 8];
                if (s_we[g]) begin
                    plan.push_back(mk({2'b00, a}, 1'b1, 2'b00, 1'b0, '0, 1'b0));
                    plan.push_back(mk({2'b01, w}, 1'b1, 2'b00, 1'b0, '0, 1'b0));
                    mem[a] = w;
                end else begin
                    plan.push_back(mk({2'b10, a}, 1'b1, 2'b00, 1'b0, '0, 1'b0));
                    plan.push_back(mk(10'h300, 1'b1, 2'b00, 1'b0, '0, 1'b0));
                    if (s_dly < TO) begin
                        for (int i = 0; i <= s_dly; i++)
                            plan.push_back(mk('0, 1'b0, 2'b00, 1'b0, '0, 1'b0));
                        plan.push_back(mk('0, 1'b0, 2'(1 << g), 1'b1, mem[a], 1'b0));
                        tx_at   = slot + 3 + s_dly;
                        tx_data = mem[a];
                        rd_end  = slot + 4 + s_dly;
                    end else begin
                        for (int i = 0; i < TO; i++)
                            plan.push_back(mk('0, 1'b0, 2'b00, 1'b0, '0, 1'b0));
                        plan.push_back(mk('0, 1'b0, 2'(1 << g), 1'b1, 8'h00, 1'b1));
                        tx_at  = -1;
                        rd_end = slot + 3 + TO;
                    end
                end
            end
        end
    endtask

    task automatic clear_logs();
        rx_log.delete(); gnt_log.delete(); hs_log.delete();
        rsp_slot_log.delete(); rspv_log.delete(); rdat_log.delete(); err_log.delete();
    endtask

    initial begin
        int h0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
        s_rst = 1'b1;
        repeat (2) cycle();
        s_rst = 1'b0;
        cycle();

        // Case 1: requester 0 writes 0xA5 to 0x10.
        clear_logs();
        set_req(2'b01, 2'b01, 16'h0010, 16'h00A5);
        cycle();
        s_valid = 2'b00;
        repeat (4) cycle();
        chk("t1_rx_count", 32'(rx_log.size()), 32'd2);
        chk("t1_cmd_addr", 32'(rx(0)), 32'h010);
        chk("t1_cmd_wdata", 32'(rx(1)), 32'h1A5);
        chk("t1_no_rsp", 32'(rsp_slot_log.size()), 32'd0);

        // Case 2: requester 1 reads 0x10 back, RAM answers immediately.
        clear_logs();
        set_req(2'b10, 2'b00, 16'h1000, 16'h0000);
        s_dly = 0;
        cycle();
        s_valid = 2'b00;
        repeat (6) cycle();
        chk("t2_cmd_addr", 32'(rx(0)), 32'h210);
        chk("t2_cmd_rdata", 32'(rx(1)), 32'h300);
        chk("t2_rsp_count", 32'(rsp_slot_log.size()), 32'd1);
        if (rsp_slot_log.size() == 1 && hs_log.size() == 1) begin
            chk("t2_rsp_latency", 32'(rsp_slot_log[0] - hs_log[0]), 32'd4);
            chk("t2_rsp_valid", 32'(rspv_log[0]), 32'h2);
            chk("t2_rsp_rdata", 32'(rdat_log[0]), 32'hA5);
            chk("t2_rsp_err", 32'(err_log[0]), 32'h0);
        end

        // Case 3: both requesters stream writes.
        clear_logs();
        set_req(2'b11, 2'b11, 16'h4433, 16'h2211);
        repeat (12) cycle();
        s_valid = 2'b00;
        repeat (3) cycle();
        chk("t3_grant_count", 32'(gnt_log.size()), 32'd4);
        if (gnt_log.size() == 4) begin
            chk("t3_grant0", 32'(gnt_log[0]), 32'd0);
            chk("t3_grant1", 32'(gnt_log[1]), 32'd1);
            chk("t3_grant2", 32'(gnt_log[2]), 32'd0);
            chk("t3_grant3", 32'(gnt_log[3]), 32'd1);
            for (int i = 1; i < 4; i++)
                chk("t3_spacing", 32'(hs_log[i] - hs_log[i-1]), 32'd3);
        end

        // Case 4: RAM never answers.
        clear_logs();
        set_req(2'b01, 2'b00, 16'h0010, 16'h0000);
        s_dly = TO + 5;
        cycle();
        s_valid = 2'b00;
        repeat (TO + 6) cycle();
        chk("t4_rsp_count", 32'(rsp_slot_log.size()), 32'd1);
        if (rsp_slot_log.size() == 1 && hs_log.size() == 1) begin
            chk("t4_timeout_latency", 32'(rsp_slot_log[0] - hs_log[0]), 32'd11);
            chk("t4_rsp_valid", 32'(rspv_log[0]), 32'h1);
            chk("t4_rsp_rdata", 32'(rdat_log[0]), 32'h00);
            chk("t4_rsp_err", 32'(err_log[0]), 32'h1);
        end

        // Case 5: reset while waiting for read data, then a clean write/read.
        clear_logs();
        set_req(2'b01, 2'b00, 16'h0020, 16'h0000);
        cycle();
        s_valid = 2'b00;
        repeat (4) cycle();
        s_rst = 1'b1;
        cycle();
        s_rst = 1'b0;
        repeat (TO + 4) cycle();
        chk("t5_aborted_no_rsp", 32'(rsp_slot_log.size()), 32'd0);
        set_req(2'b10, 2'b10, 16'h3C00, 16'h5E00);
        cycle();
        s_valid = 2'b00;
        repeat (3) cycle();
        clear_logs();
        set_req(2'b10, 2'b00, 16'h3C00, 16'h0000);
        s_dly = 1;
        cycle();
        s_valid = 2'b00;
        repeat (7) cycle();
        chk("t5_cmd_addr", 32'(rx(0)), 32'h23C);
        chk("t5_cmd_rdata", 32'(rx(1)), 32'h300);
        chk("t5_rsp_count", 32'(rsp_slot_log.size()), 32'd1);
        if (rsp_slot_log.size() == 1) begin
            chk("t5_rsp_valid", 32'(rspv_log[0]), 32'h2);
            chk("t5_rsp_rdata", 32'(rdat_log[0]), 32'h5E);
        end

        // Case 6: spurious RAM strobes and inputs changing after the handshake.
        clear_logs();
        s_spur = 1'b1;
        repeat (5) cycle();
        chk("t6_spurious_no_rsp", 32'(rsp_slot_log.size()), 32'd0);
        set_req(2'b01, 2'b01, 16'h0077, 16'h0099);
        cycle();
        set_req(2'b00, 2'b00, 16'hEEEE, 16'h1111);
        repeat (4) cycle();
        s_spur = 1'b0;
        chk("t6_latched_addr", 32'(rx(0)), 32'h077);
        chk("t6_latched_wdata", 32'(rx(1)), 32'h199);
        chk("t6_no_rsp", 32'(rsp_slot_log.size()), 32'd0);

        // Random traffic against the model.
        repeat (3000) begin
            s_valid = 2'($urandom);
            s_we    = 2'($urandom);
            s_addr  = 16'($urandom);
            s_wdata = 16'($urandom);
            s_dly   = $urandom_range(0, TO + 2);
            s_rst   = ($urandom_range(0, 199) == 0);
            s_spur  = ($urandom_range(0, 3) == 0);
            cycle();
        end
        s_rst = 1'b0;
        s_spur = 1'b0;
        s_valid = 2'b00;
        repeat (20) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Shares the 10-bit-command single-port RAM (opcode din[9:8]: 00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data) between two requesters.
- Each requester issues complete byte transactions (write addr+data, or read addr). The block arbitrates between them round-robin and sequences the RAM command words.
- It captures the RAM read response and routes it back to the granted requester, with a timeout if the RAM never responds.
- Sits between the requester fabric and the RAM, in place of the SPI slave as the RAM command source.

Parameters:
ADDR_SIZE, 8, RAM address / data byte width; command word is ADDR_SIZE+2 bits
TIMEOUT, 8, max cycles to wait for ram_tx_valid after issuing a rd-data command (must be ≥2)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
req_valid  in  2  per-requester transaction request (bit i = requester i)
req_we  in  2  per-requester: 1 = write, 0 = read
req_addr  in  2*ADDR_SIZE  per-requester address, requester i at [i*8+:8]
req_wdata  in  2*ADDR_SIZE  per-requester write data, same packing
req_ready  out  2  per-requester accept; handshake when valid&ready
rsp_valid  out  2  per-requester one-cycle read-response strobe
rsp_rdata  out  ADDR_SIZE  read data, valid with any rsp_valid bit
rsp_err  out  1  qualifies rsp_valid: 1 = timeout, rdata = 0
ram_din  out  ADDR_SIZE+2  command word to RAM
ram_rx_valid  out  1  command word strobe to RAM
ram_dout  in  ADDR_SIZE  RAM read data
ram_tx_valid  in  1  RAM read-data strobe
busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; last_grant=1, so requester 0 wins the first tie.
  - ram_din=0, ram_rx_valid=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - Timeout counter=0; latched transaction fields cleared.
- Reset mid-transaction aborts it: no rsp_valid is produced and no further RAM commands are issued.
- Arbitration (combinational, IDLE only):
  - One requester valid: it is granted.
  - Both valid: grant the requester ≠ last_grant.
  - req_ready = grant bit while state==IDLE, else 0; at most one bit is high.
- Handshake (cycle T): latch we/addr/wdata and the granted id, update last_grant, leave IDLE.
- FSM states: IDLE, CMD_ADDR, CMD_WDATA, CMD_RDATA, WAIT_RD, RESP.
  - IDLE → CMD_ADDR on handshake.
  - CMD_ADDR (T+1): ram_rx_valid=1, ram_din={00,addr} for a write or {10,addr} for a read. Next state: CMD_WDATA for a write, CMD_RDATA for a read.
  - CMD_WDATA (T+2): ram_rx_valid=1, ram_din={01,wdata} → IDLE. Writes produce no response; next handshake is possible at T+3.
  - CMD_RDATA (T+2): ram_rx_valid=1, ram_din={11,8'h00} → WAIT_RD; clear the timeout counter.
  - WAIT_RD: ram_rx_valid=0; the counter increments each cycle.
    - On ram_tx_valid: register ram_dout, set rsp_err=0 → RESP.
    - If the counter reaches TIMEOUT-1 without ram_tx_valid: rdata=0, rsp_err=1 → RESP.
  - RESP: rsp_valid[id]=1 for exactly this one cycle → IDLE.
  - Nominal read: RAM tx_valid at T+3, rsp_valid at T+4, next handshake possible at T+5.
- ram_din and ram_rx_valid are registered outputs.
- ram_rx_valid=0 and ram_din=0 in IDLE, WAIT_RD and RESP.
- ram_tx_valid outside WAIT_RD is ignored.
- rsp_rdata and rsp_err hold their last value until the next RESP.
- Requester inputs are sampled only at the handshake; later changes do not affect the in-flight transaction.
- A requester may drop req_valid before it is granted; no transaction is recorded.
- An address of 8'hFF is not special; addresses do not wrap or increment.

Test Plan:
1. Reset, then requester0 writes addr 0x10 data 0xA5 → ram_din 0x010 at T+1 and 0x1A5 at T+2 with ram_rx_valid; IDLE at T+3; no rsp_valid.
2. Requester1 reads 0x10 after case 1 (real RAM model) → ram_din 0x210 then 0x300; rsp_valid=2'b10, rsp_rdata 0xA5, rsp_err 0 at T+4.
3. Both requesters valid continuously with writes → grants alternate 0,1,0,1 starting with 0; each handshake 3 cycles apart.
4. Read with ram_tx_valid held low → rsp_valid for the requester with rsp_err=1 and rdata 0x00 exactly TIMEOUT cycles after entering WAIT_RD; back to IDLE.
5. Assert rst_n=0 during WAIT_RD, then release → no rsp_valid; all outputs 0; a following read from requester 1 is issued correctly.
6. Spurious ram_tx_valid in IDLE, and requester inputs changed right after the handshake → no rsp_valid; RAM commands use the latched addr/data.
